complete_arbiter: RTL and testbench

// - Shares the WAYS ROB completion ports among NUM_FU functional units.
// - Sits between FU outputs and rob.rob_complete_in / CDB broadcast.
// - Each FU has a one-entry holding register. A round-robin picker grants
//   up to WAYS held results per cycle. Losers hold and backpressure their FU.

---
 rtl/complete_arbiter_pkg.sv | 35 +++
 rtl/complete_rr_picker.sv | 41 ++++
 rtl/complete_arbiter.sv | 75 +++++++
 tb/tb_complete_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/complete_arbiter_pkg.sv
// Shared types and sizes for the completion arbiter: FU result packets,
// ROB completion and CDB lane packets, and the picker's lane selection.
package complete_arbiter_pkg;

    localparam int NUM_FU = 6;
    localparam int WAYS   = 3;
    localparam int PTR_W  = $clog2(NUM_FU);

    typedef struct packed {
        logic       valid;
        logic [4:0] rob_idx;
        logic [5:0] t_idx;
    } fu_complete_packet_t;

    typedef struct packed {
        logic       complete;
        logic [4:0] rob_idx;
    } complete_rob_packet_t;

    typedef struct packed {
        logic       valid;
        logic [5:0] t_idx;
    } cdb_packet_t;

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] fu_idx;
    } lane_sel_t;

    // Callers pass non-negative indices below 2*NUM_FU.
    function automatic logic [PTR_W-1:0] fu_wrap(input int idx);
        return PTR_W'(idx % NUM_FU);
    endfunction

endpackage

// File: rtl/complete_rr_picker.sv
// Round-robin picker: scans held entries from rr_ptr and hands the first
// WAYS valid ones to lanes 0..WAYS-1 in scan order.
module complete_rr_picker
    import complete_arbiter_pkg::*;
(
    input  logic [NUM_FU-1:0] held_valid,
    input  logic [PTR_W-1:0]  rr_ptr,
    output logic [NUM_FU-1:0] grant,
    output lane_sel_t         lane_sel [WAYS],
    output logic [PTR_W-1:0]  next_ptr
);

    int               won;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant    = '0;
        next_ptr = rr_ptr;
        won      = 0;
        idx      = '0;
        for (int k = 0; k < WAYS; k++) begin
            lane_sel[k] = '0;
        end
        for (int j = 0; j < NUM_FU; j++) begin
            idx = fu_wrap(int'(rr_ptr) + j);
            if (held_valid[idx] && won < WAYS) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < WAYS; k++) begin
                    if (k == won) begin
                        lane_sel[k].valid  = 1'b1;
                        lane_sel[k].fu_idx = idx;
                    end
                end
                won = won + 1;
                // Pointer lands just past the last winner so losers lead next cycle.
                next_ptr = fu_wrap(int'(idx) + 1);
            end
        end
    end

endmodule

// File: rtl/complete_arbiter.sv
// Completion arbiter: one holding slot per FU, round-robin drain of up to
// WAYS results per cycle onto the ROB completion and CDB lanes.
module complete_arbiter
    import complete_arbiter_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 squash,
    input  fu_complete_packet_t  fu_req_in        [NUM_FU],
    output logic [NUM_FU-1:0]    fu_ready_out,
    output complete_rob_packet_t rob_complete_out [WAYS],
    output cdb_packet_t          cdb_out          [WAYS],
    output logic [PTR_W-1:0]     rr_ptr_out
);

    fu_complete_packet_t held_reg  [NUM_FU];
    fu_complete_packet_t held_next [NUM_FU];
    logic [NUM_FU-1:0]   held_valid_reg;
    logic [NUM_FU-1:0]   held_valid_next;
    logic [NUM_FU-1:0]   grant;
    logic [NUM_FU-1:0]   accept;
    logic [PTR_W-1:0]    rr_ptr_reg;
    logic [PTR_W-1:0]    rr_ptr_next;
    logic [PTR_W-1:0]    pick_ptr;
    lane_sel_t           lane_sel [WAYS];

    complete_rr_picker u_picker (
        .held_valid (held_valid_reg),
        .rr_ptr     (rr_ptr_reg),
        .grant      (grant),
        .lane_sel   (lane_sel),
        .next_ptr   (pick_ptr)
    );

    // A slot being drained this cycle can take a new result on the same edge.
    assign fu_ready_out = ~held_valid_reg | grant;
    assign rr_ptr_next  = squash ? rr_ptr_reg : pick_ptr;
    assign rr_ptr_out   = rr_ptr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_slot
            assign accept[gi]          = fu_req_in[gi].valid & fu_ready_out[gi] & ~squash;
            assign held_valid_next[gi] = ~squash & (accept[gi] | (held_valid_reg[gi] & ~grant[gi]));
            assign held_next[gi]       = accept[gi] ? fu_req_in[gi] : held_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            held_valid_reg <= '0;
            rr_ptr_reg     <= '0;
        end else begin
            held_valid_reg <= held_valid_next;
            rr_ptr_reg     <= rr_ptr_next;
        end
        held_reg <= held_next;
    end

    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_lane
            always_comb begin
                rob_complete_out[gi] = '0;
                cdb_out[gi]          = '0;
                if (lane_sel[gi].valid) begin
                    rob_complete_out[gi].complete = 1'b1;
                    rob_complete_out[gi].rob_idx  = held_reg[lane_sel[gi].fu_idx].rob_idx;
                    cdb_out[gi].valid             = 1'b1;
                    cdb_out[gi].t_idx             = held_reg[lane_sel[gi].fu_idx].t_idx;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_complete_arbiter.sv
// Directed table-driven bench for complete_arbiter, plus a hand-written
// sustained-oversubscription sequence.
module tb_complete_arbiter;
    import complete_arbiter_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 squash = 1'b0;
    fu_complete_packet_t  fu_req_in        [NUM_FU];
    logic [NUM_FU-1:0]    fu_ready_out;
    complete_rob_packet_t rob_complete_out [WAYS];
    cdb_packet_t          cdb_out          [WAYS];
    logic [PTR_W-1:0]     rr_ptr_out;

    int tests_run = 0;
    int tests_failed = 0;

    complete_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .squash           (squash),
        .fu_req_in        (fu_req_in),
        .fu_ready_out     (fu_ready_out),
        .rob_complete_out (rob_complete_out),
        .cdb_out          (cdb_out),
        .rr_ptr_out       (rr_ptr_out)
    );

    always #5 clock = ~clock;

    // FU i drives rob_idx = rb + i, t_idx = tb + i; expectations are post-edge values.
    typedef struct {
        logic            rst_n;
        logic            sq;
        logic [5:0]      vmask;
        logic [4:0]      rb;
        logic [5:0]      tb;
        logic [2:0]      e_lv;
        logic [2:0][4:0] e_rob;
        logic [2:0][5:0] e_t;
        logic [5:0]      e_ready;
        logic [2:0]      e_ptr;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst_n, input logic sq, input logic [5:0] vmask,
                                input logic [4:0] rb, input logic [5:0] tb, input logic [2:0] lv,
                                input logic [4:0] r0, input logic [5:0] t0,
                                input logic [4:0] r1, input logic [5:0] t1,
                                input logic [4:0] r2, input logic [5:0] t2,
                                input logic [5:0] ready, input logic [2:0] ptr);
        vec_t v;
        v.rst_n = rst_n; v.sq = sq; v.vmask = vmask; v.rb = rb; v.tb = tb;
        v.e_lv = lv;
        v.e_rob[0] = r0; v.e_rob[1] = r1; v.e_rob[2] = r2;
        v.e_t[0] = t0; v.e_t[1] = t1; v.e_t[2] = t2;
        v.e_ready = ready; v.e_ptr = ptr;
        return v;
    endfunction

    task automatic drive(input logic rst_n, input logic sq, input logic [5:0] vmask,
                         input logic [4:0] rb, input logic [5:0] tb);
        reset  = rst_n;
        squash = sq;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_req_in[i].valid   = vmask[i];
            fu_req_in[i].rob_idx = 5'(rb + 5'(i));
            fu_req_in[i].t_idx   = 6'(tb + 6'(i));
        end
    endtask

    task automatic check(input string name, input int row, input logic [2:0] lv,
                         input logic [2:0][4:0] e_rob, input logic [2:0][5:0] e_t,
                         input logic [5:0] e_ready, input logic [2:0] e_ptr);
        logic [38:0] got_l, exp_l;
        got_l = '0;
        exp_l = '0;
        for (int k = 0; k < WAYS; k++) begin
            got_l[k*13 +: 13] = {rob_complete_out[k], cdb_out[k]};
            exp_l[k*13 +: 13] = lv[k] ? {1'b1, e_rob[k], 1'b1, e_t[k]} : 13'd0;
        end
        tests_run++;
        if (got_l !== exp_l) begin
            tests_failed++;
            $display("FAIL %s[%0d] lanes got %h exp %h", name, row, got_l, exp_l);
        end
        tests_run++;
        if (fu_ready_out !== e_ready) begin
            tests_failed++;
            $display("FAIL %s[%0d] fu_ready got %b exp %b", name, row, fu_ready_out, e_ready);
        end
        tests_run++;
        if (rr_ptr_out !== e_ptr) begin
            tests_failed++;
            $display("FAIL %s[%0d] rr_ptr got %0d exp %0d", name, row, rr_ptr_out, e_ptr);
        end
        $display("[TB] %s[%0d] lanes=%h ready=%b ptr=%0d", name, row, got_l, fu_ready_out, rr_ptr_out);
    endtask

    initial begin
        logic [2:0][4:0] er;
        logic [2:0][5:0] et;

        // reset with busy inputs
        vecs[0]  = mk(0, 1, 6'h3F, 5'd17, 6'd42, 3'b000, 0,0, 0,0, 0,0, 6'h3F, 0);
        // single FU2: rob 5, t 9; pointer moves to 3 after the grant edge
        vecs[1]  = mk(1, 0, 6'b000100, 5'd3, 6'd7, 3'b001, 5,9, 0,0, 0,0, 6'h3F, 0);
        vecs[2]  = mk(1, 0, 6'b000000, 5'd0, 6'd0, 3'b000, 0,0, 0,0, 0,0, 6'h3F, 3);
        // back to ptr 0, then oversubscribe all six
        vecs[3]  = mk(0, 0, 6'b000000, 5'd0, 6'd0, 3'b000, 0,0, 0,0, 0,0, 6'h3F, 0);
        vecs[4]  = mk(1, 0, 6'h3F, 5'd0, 6'd16, 3'b111, 0,16, 1,17, 2,18, 6'b000111, 0);
        vecs[5]  = mk(1, 0, 6'h00, 5'd0, 6'd0, 3'b111, 3,19, 4,20, 5,21, 6'h3F, 3);
        vecs[6]  = mk(1, 0, 6'h00, 5'd0, 6'd0, 3'b000, 0,0, 0,0, 0,0, 6'h3F, 0);
        // FU3 alone moves ptr to 4, then wrap with FU0,1,5 held
        vecs[7]  = mk(1, 0, 6'b001000, 5'd10, 6'd30, 3'b001, 13,33, 0,0, 0,0, 6'h3F, 0);
        vecs[8]  = mk(1, 0, 6'b100011, 5'd20, 6'd40, 3'b111, 25,45, 20,40, 21,41, 6'h3F, 4);
        vecs[9]  = mk(1, 0, 6'h00, 5'd0, 6'd0, 3'b000, 0,0, 0,0, 0,0, 6'h3F, 2);
        // FU1 streams every cycle for 8 cycles
        for (int k = 0; k < 8; k++) begin
            vecs[10+k] = mk(1, 0, 6'b000010, 5'(k), 6'(32+k), 3'b001,
                            5'(k+1), 6'(33+k), 0,0, 0,0, 6'h3F, 2);
        end
        vecs[18] = mk(1, 0, 6'h00, 5'd0, 6'd0, 3'b000, 0,0, 0,0, 0,0, 6'h3F, 2);
        // all held, then squash with a new FU3 request
        vecs[19] = mk(1, 0, 6'h3F, 5'd0, 6'd0, 3'b111, 2,2, 3,3, 4,4, 6'b011100, 2);
        vecs[20] = mk(1, 1, 6'b001000, 5'd8, 6'd8, 3'b000, 0,0, 0,0, 0,0, 6'h3F, 2);
        vecs[21] = mk(1, 0, 6'h00, 5'd0, 6'd0, 3'b000, 0,0, 0,0, 0,0, 6'h3F, 2);
        // mid-operation reset drops held results and wins over accept
        vecs[22] = mk(1, 0, 6'h3F, 5'd1, 6'd1, 3'b111, 3,3, 4,4, 5,5, 6'b011100, 2);
        vecs[23] = mk(0, 0, 6'h3F, 5'd1, 6'd1, 3'b000, 0,0, 0,0, 0,0, 6'h3F, 0);

        for (int r = 0; r < NV; r++) begin
            drive(vecs[r].rst_n, vecs[r].sq, vecs[r].vmask, vecs[r].rb, vecs[r].tb);
            @(posedge clock);
            #1;
            check("vec", r, vecs[r].e_lv, vecs[r].e_rob, vecs[r].e_t, vecs[r].e_ready, vecs[r].e_ptr);
        end

        // sustained demand on all FUs: halves alternate, no FU waits over 2 cycles
        for (int c = 0; c < 6; c++) begin
            drive(1, 0, 6'h3F, 5'd0, 6'd8);
            @(posedge clock);
            #1;
            for (int k = 0; k < WAYS; k++) begin
                er[k] = (c % 2 == 1) ? 5'(k + 3) : 5'(k);
                et[k] = (c % 2 == 1) ? 6'(k + 11) : 6'(k + 8);
            end
            check("sustain", c, 3'b111, er, et,
                  (c % 2 == 1) ? 6'b111000 : 6'b000111, (c % 2 == 1) ? 3'd3 : 3'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
